challenge_serializer: RTL and testbench

Parallel-to-serial transmitter for the CMAC challenge path. It accepts a WIDTH-bit challenge word over a valid/ready handshake and shifts it out MSB-first, one bit per enabled clock. The bit stream is the counterpart of the 64-bit shift-left challenge collector: a collector doing `{reg[62:0], bit}` on every `bit_valid` reassembles the original word exactly. It sits between the challenge source (register or ASG-derived word) and the serial link or SPI shift stage.

---
 rtl/cmac_pkg.sv | 21 ++
 rtl/challenge_serializer.sv | 110 +++++++++++
 tb/tb_challenge_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmac_pkg
// Description : Shared types and constants for the CMAC challenge path
//               (serializer transmit side and shift-left collector side).
// Revision    : 1.0 - initial release
// ============================================================================
package cmac_pkg;

    // Native challenge word length shared by serializer and collector.
    localparam int CHALLENGE_W = 64;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

endpackage : cmac_pkg
`default_nettype wire

// File: rtl/challenge_serializer.sv
`default_nettype none
// ============================================================================
// Module      : challenge_serializer
// Description : Parallel-to-serial challenge transmitter. Accepts a WIDTH-bit
//               word on a valid/ready handshake and emits it MSB-first, one
//               bit per enabled clock, so that a {reg[W-2:0], bit} collector
//               rebuilds the original word.
// Revision    : 1.0 - initial release
// ============================================================================
module challenge_serializer
    import cmac_pkg::*;
#(
    parameter int WIDTH = CHALLENGE_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             enable,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [CNT_W-1:0] bit_index,
    output logic             busy,
    output logic             done
);

    // Index of the last bit of a word (terminal count).
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    // Ready only when a new word can be taken, and never while reset is held.
    assign word_ready = reset && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_count == c_last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus load/step strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (word_valid && word_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // A word offered during DONE goes straight back into SHIFT.
                if (word_valid && word_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register and bit counter; counter parks at 0 after the last bit
    // so it never wraps through an out-of-range value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_shreg <= word_in;
            r_count <= '0;
        end else if (w_step) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_count <= w_last ? '0 : (r_count + CNT_W'(1));
        end
    end

    assign bit_out   = r_shreg[WIDTH-1];
    assign bit_index = r_count;
    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == DONE);
    assign bit_valid = (r_state == SHIFT) && enable;

endmodule : challenge_serializer
`default_nettype wire

// File: tb/tb_challenge_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_challenge_serializer
// Description : Self-checking bench for challenge_serializer: a WIDTH=8
//               vector table plus directed WIDTH=64 transfer sequences with a
//               reference shift-left collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_challenge_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- WIDTH = 8 instance ----------------
    logic       r8_reset = 1'b0;
    logic [7:0] r8_word  = '0;
    logic       r8_valid = 1'b0;
    logic       r8_en    = 1'b0;
    logic       w8_ready, w8_bit, w8_bv, w8_busy, w8_done;
    logic [2:0] w8_idx;

    challenge_serializer #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (r8_reset),
        .word_in    (r8_word),
        .word_valid (r8_valid),
        .word_ready (w8_ready),
        .enable     (r8_en),
        .bit_out    (w8_bit),
        .bit_valid  (w8_bv),
        .bit_index  (w8_idx),
        .busy       (w8_busy),
        .done       (w8_done)
    );

    // ---------------- WIDTH = 64 instance ----------------
    logic        r64_reset = 1'b0;
    logic [63:0] r64_word  = '0;
    logic        r64_valid = 1'b0;
    logic        r64_en    = 1'b0;
    logic        w64_ready, w64_bit, w64_bv, w64_busy, w64_done;
    logic [5:0]  w64_idx;

    challenge_serializer u_dut64 (
        .clk        (clk),
        .reset      (r64_reset),
        .word_in    (r64_word),
        .word_valid (r64_valid),
        .word_ready (w64_ready),
        .enable     (r64_en),
        .bit_out    (w64_bit),
        .bit_valid  (w64_bv),
        .bit_index  (w64_idx),
        .busy       (w64_busy),
        .done       (w64_done)
    );

    localparam logic [63:0] c_w1 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] c_w2 = 64'h01234567_89ABCDEF;
    localparam logic [63:0] c_w3 = 64'h80000000_00000001;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] word;
        logic       en;
        logic       bo;
        logic       bv;
        logic [2:0] idx;
        logic       busy;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word on the 64-bit instance; returns just after the handshake edge.
    task automatic offer64(input logic [63:0] w);
        r64_word  = w;
        r64_valid = 1'b1;
        @(negedge clk);
        chk("w64_ready_before_load", {63'd0, w64_ready}, 64'd1);
        tick();
        r64_valid = 1'b0;
    endtask

    // Run one 64-bit transfer starting the cycle after its handshake edge.
    // Checks each SHIFT cycle against a bit model, collects bits on bit_valid,
    // and reports how many edges after the handshake done was visible.
    task automatic xfer64(input logic [63:0] w, input int stall_at, input int stall_len,
                          input int ign_at, input logic [63:0] next_w, input bit do_next,
                          output int done_edge, output logic [63:0] coll);
        int  m;
        bit  found;
        m         = 0;
        found     = 1'b0;
        coll      = '0;
        done_edge = -1;
        for (int c = 0; c < 300; c++) begin
            r64_en    = !(c >= stall_at && c < stall_at + stall_len);
            r64_valid = (c == ign_at);
            if (c == ign_at) r64_word = '1;
            @(negedge clk);
            if (c == 0) chk("w64_busy_first_cycle", {63'd0, w64_busy}, 64'd1);
            if (w64_busy) begin
                chk("w64_bit_out",   {63'd0, w64_bit},   {63'd0, w[63-m]});
                chk("w64_bit_index", {58'd0, w64_idx},   64'(m));
                chk("w64_bit_valid", {63'd0, w64_bv},    {63'd0, r64_en});
                chk("w64_ready_busy",{63'd0, w64_ready}, 64'd0);
                if (w64_bv) begin
                    coll = {coll[62:0], w64_bit};
                    m++;
                end
            end
            if (w64_done) begin
                found     = 1'b1;
                done_edge = c;
                chk("w64_ready_done", {63'd0, w64_ready}, 64'd1);
                chk("w64_busy_done",  {63'd0, w64_busy},  64'd0);
                if (do_next) begin
                    r64_word  = next_w;
                    r64_valid = 1'b1;
                end
                break;
            end
            tick();
        end
        if (!found) chk("w64_done_timeout", 64'd0, 64'd1);
        if (do_next) begin
            tick();
            r64_valid = 1'b0;
        end
    endtask

    initial begin
        int          de, de2;
        logic [63:0] coll;

        // -------- WIDTH=8 table: A5 load, back-to-back 3C, reset mid-shift --------
        //            rst vld word  en   bo bv idx  busy dn rdy
        tbl[0]  = '{1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,8'hA5,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b0,1'b1};
        tbl[2]  = '{1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd1,1'b1,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd2,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd3,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd4,1'b1,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd5,1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd6,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd7,1'b1,1'b0,1'b0};
        // DONE (handshake+9) with a new word offered
        tbl[10] = '{1'b1,1'b1,8'h3C,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b1,1'b1};
        tbl[11] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd0,1'b1,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,3'd1,1'b1,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,3'd2,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd2,1'b1,1'b0,1'b0};
        // reset asserted mid-shift: ready drops at once, rest clears next edge
        tbl[15] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,3'd3,1'b1,1'b0,1'b0};
        tbl[16] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b0,1'b1};
        tbl[17] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b0,1'b1};
        tbl[18] = '{1'b1,1'b0,8'h00,1'b1, 1'b0,1'b0,3'd0,1'b0,1'b0,1'b1};

        tick();
        tick();
        for (int i = 0; i < 19; i++) begin
            r8_reset = tbl[i].rst;
            r8_valid = tbl[i].vld;
            r8_word  = tbl[i].word;
            r8_en    = tbl[i].en;
            @(negedge clk);
            chk($sformatf("w8_row%0d", i),
                {56'd0, w8_bit, w8_bv, w8_idx, w8_busy, w8_done, w8_ready},
                {56'd0, tbl[i].bo, tbl[i].bv, tbl[i].idx, tbl[i].busy, tbl[i].dn, tbl[i].rdy});
            tick();
        end

        // -------- WIDTH=64: reset state --------
        @(negedge clk);
        chk("w64_reset_outputs",
            {56'd0, w64_bit, w64_bv, w64_idx, w64_busy, w64_done, w64_ready}, 64'd0);
        tick();
        r64_reset = 1'b1;
        r64_en    = 1'b1;

        // Plain transfer: done 64 edges after handshake (cycle N+65)
        offer64(c_w1);
        xfer64(c_w1, 1000, 0, 1000, '0, 1'b0, de, coll);
        chk("plain_done_edge", 64'(de), 64'd64);
        chk("plain_collected", coll, c_w1);
        tick();

        // Stall of 3 cycles while bit 6 is presented: done at N+68
        offer64(c_w1);
        xfer64(c_w1, 6, 3, 1000, '0, 1'b0, de, coll);
        chk("stall_done_edge", 64'(de), 64'd67);
        chk("stall_collected", coll, c_w1);
        tick();

        // Back-to-back: second word accepted in DONE, 130 cycles total
        offer64(c_w1);
        xfer64(c_w1, 1000, 0, 1000, c_w2, 1'b1, de, coll);
        chk("b2b_first_collected", coll, c_w1);
        xfer64(c_w2, 1000, 0, 1000, '0, 1'b0, de2, coll);
        chk("b2b_second_collected", coll, c_w2);
        chk("b2b_total_edges", 64'(de + 1 + de2), 64'd129);
        tick();

        // word_valid with all-ones while busy is ignored
        offer64(c_w1);
        xfer64(c_w1, 1000, 0, 20, '0, 1'b0, de, coll);
        chk("ignore_done_edge", 64'(de), 64'd64);
        chk("ignore_collected", coll, c_w1);
        tick();

        // Reset for one cycle after bit 10 has been consumed
        offer64(c_w1);
        repeat (11) tick();
        r64_reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_low", {63'd0, w64_ready}, 64'd0);
        tick();
        r64_reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            {56'd0, w64_bit, w64_bv, w64_idx, w64_busy, w64_done, w64_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("rst_mid_no_done", {63'd0, w64_done}, 64'd0);
        end
        tick();
        offer64(c_w3);
        xfer64(c_w3, 1000, 0, 1000, '0, 1'b0, de, coll);
        chk("post_reset_done_edge", 64'(de), 64'd64);
        chk("post_reset_collected", coll, c_w3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_challenge_serializer
`default_nettype wire
